// File: rtl/reflet_float_mult_normalize_pkg.sv
// Shared definitions for the floating-point multiplier back end:
// exponent/NaN constants derived from the format widths, and FSM state encodings.
package reflet_float_mult_normalize_pkg;

  // Sequencer states of the normalize/round back end.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_NORM  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } norm_state_t;

  // Exponent bias: 2^(E-1)-1.
  function automatic int exp_bias(input int exponent_size);
    return (1 << (exponent_size - 1)) - 1;
  endfunction

  // All-ones exponent, used for infinities and NaN.
  function automatic int exp_max(input int exponent_size);
    return (1 << exponent_size) - 1;
  endfunction

  // Canonical NaN: sign 0, exponent all ones, mantissa MSB set, rest zero.
  // Returned right-aligned in 64 bits; callers size-cast to their word width.
  function automatic logic [63:0] canonical_nan(input int exponent_size,
                                                input int mantissa_size);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exponent_size; i++) begin
      r[mantissa_size + i] = 1'b1;
    end
    r[mantissa_size - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/reflet_float_round_ne.sv
// Combinational round-to-nearest-even of a stored mantissa with guard/sticky bits.
// carry is set when rounding overflows the mantissa field; the caller then
// bumps the exponent and clears the mantissa.
module reflet_float_round_ne #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] mantissa,
  input  logic             guard,
  input  logic             sticky,
  output logic [WIDTH-1:0] rounded,
  output logic             carry
);

  logic inc;

  // Round up when above the halfway point, or exactly halfway and odd.
  assign inc = guard & (sticky | mantissa[0]);
  assign {carry, rounded} = {1'b0, mantissa} + {{WIDTH{1'b0}}, inc};

endmodule

// File: rtl/reflet_float_mult_normalize.sv
// Back end of the floating-point multiplier: normalizes the double-width
// mantissa product, rounds to nearest-even, handles overflow/underflow and
// special operands, and packs the final result.
//
// Handshake: enable is level-held by the requester for the whole operation.
// The upstream multiplier raises product_ready (product stable while high);
// this block then raises ready with result valid and keeps it high until
// enable drops. enable low in any state returns to IDLE on the next edge and
// clears ready; result keeps its last value.
module reflet_float_mult_normalize
  import reflet_float_mult_normalize_pkg::*;
#(
  parameter int exponent_size = 5,
  parameter int mantissa_size = 10
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [2*mantissa_size+1:0]             product,
  input  logic                                   product_ready,
  input  logic                                   sign_a,
  input  logic                                   sign_b,
  input  logic [exponent_size-1:0]               exp_a,
  input  logic [exponent_size-1:0]               exp_b,
  input  logic                                   nan_in,
  input  logic                                   inf_in,
  input  logic                                   zero_in,
  output logic [exponent_size+mantissa_size:0]   result,
  output logic                                   ready,
  output norm_state_t                            state_dbg
);

  localparam int M  = mantissa_size;
  localparam int E  = exponent_size;
  localparam int W  = 1 + E + M;
  localparam int XW = E + 2;

  localparam logic signed [XW-1:0] BIAS_X = XW'(exp_bias(E));
  localparam logic signed [XW-1:0] EMAX_X = XW'(exp_max(E));
  localparam logic signed [XW-1:0] ZERO_X = '0;
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic [W-1:0]         NAN_WORD = W'(canonical_nan(E, M));
  localparam logic [E-1:0]         EXP_ONES = '1;

  norm_state_t state, state_next;

  // Work registers filled in NORM and consumed in ROUND.
  logic                  sign_r;
  logic signed [XW-1:0]  exp_r;
  logic [M-1:0]          mant_r;
  logic                  guard_r;
  logic                  sticky_r;
  logic                  special_r;
  logic [W-1:0]          packed_r;

  // Normalization datapath (combinational, from live inputs).
  logic                  sign_c;
  logic signed [XW-1:0]  exp_sum;
  logic signed [XW-1:0]  norm_exp;
  logic [M-1:0]          norm_mant;
  logic                  norm_guard;
  logic                  norm_sticky;
  logic                  is_special;
  logic [W-1:0]          special_word;

  // Rounding datapath (combinational, from work registers).
  logic [M-1:0]          rnd_mant;
  logic                  rnd_carry;
  logic signed [XW-1:0]  rnd_exp;
  logic [M-1:0]          rnd_frac;
  logic [W-1:0]          round_word;

  assign state_dbg = state;

  // Normalize the product: a set top bit means the product is in [2,4).
  always_comb begin
    sign_c      = sign_a ^ sign_b;
    exp_sum     = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_X;
    norm_exp    = exp_sum;
    norm_mant   = product[2*M-1:M];
    norm_guard  = product[M-1];
    norm_sticky = |product[M-2:0];
    if (product[2*M+1]) begin
      norm_exp    = exp_sum + ONE_X;
      norm_mant   = product[2*M:M+1];
      norm_guard  = product[M];
      norm_sticky = |product[M-1:0];
    end
  end

  // Special operands bypass rounding; NaN (or inf*zero) wins over inf over zero.
  always_comb begin
    is_special   = nan_in | inf_in | zero_in;
    special_word = {sign_c, {E{1'b0}}, {M{1'b0}}};
    if (nan_in || (inf_in && zero_in)) begin
      special_word = NAN_WORD;
    end else if (inf_in) begin
      special_word = {sign_c, EXP_ONES, {M{1'b0}}};
    end
  end

  reflet_float_round_ne #(
    .WIDTH (M)
  ) u_round (
    .mantissa (mant_r),
    .guard    (guard_r),
    .sticky   (sticky_r),
    .rounded  (rnd_mant),
    .carry    (rnd_carry)
  );

  // Apply the rounding carry, then saturate to infinity or flush to zero.
  always_comb begin
    rnd_exp    = exp_r;
    rnd_frac   = rnd_mant;
    if (rnd_carry) begin
      rnd_exp  = exp_r + ONE_X;
      rnd_frac = '0;
    end
    round_word = {sign_r, rnd_exp[E-1:0], rnd_frac};
    if (rnd_exp >= EMAX_X) begin
      round_word = {sign_r, EXP_ONES, {M{1'b0}}};
    end else if (rnd_exp <= ZERO_X) begin
      round_word = {sign_r, {E{1'b0}}, {M{1'b0}}};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; dropping enable aborts from any state.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_WAIT;
        ST_WAIT:  if (product_ready) state_next = ST_NORM;
        ST_NORM:  state_next = ST_ROUND;
        ST_ROUND: state_next = ST_DONE;
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath registers: capture in NORM, round in ROUND, publish in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_r    <= 1'b0;
      exp_r     <= '0;
      mant_r    <= '0;
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
      special_r <= 1'b0;
      packed_r  <= '0;
      result    <= '0;
      ready     <= 1'b0;
    end else if (!enable) begin
      ready <= 1'b0;
    end else begin
      case (state)
        ST_NORM: begin
          sign_r    <= sign_c;
          exp_r     <= norm_exp;
          mant_r    <= norm_mant;
          guard_r   <= norm_guard;
          sticky_r  <= norm_sticky;
          special_r <= is_special;
          packed_r  <= special_word;
        end
        ST_ROUND: begin
          if (!special_r) begin
            packed_r <= round_word;
          end
        end
        ST_DONE: begin
          if (!ready) begin
            result <= packed_r;
            ready  <= 1'b1;
          end
        end
        default: begin
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
